// File: rtl/lane_rotator.sv
// Keccak rho-step lane rotator: rotates one 64-bit lane by its rho offset,
// one bit per clock, behind valid/ready handshakes on both sides.
module lane_rotator #(
   parameter int unsigned N     = 64,
   parameter int unsigned IDX_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     lane_in,
   input  logic [IDX_W-1:0] lane_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     lane_out,
   output logic             busy
);

   localparam int unsigned CW = $clog2(N) + 1;

   typedef enum logic [1:0] {IDLE, ROT, HOLD} state_t;

   state_t        state;
   logic [N-1:0]  sreg;
   logic [CW-1:0] cnt;
   logic [CW-1:0] k;

   // Each step is a rotate-right by one, so a left rotation by r takes N-r steps.
   function automatic logic [CW-1:0] steps_for(input logic [IDX_W-1:0] idx);
      int unsigned i;
      int unsigned rho;
      int unsigned r;
      i = 32'(idx);
      case (i)
         0:  rho = 0;
         1:  rho = 1;
         2:  rho = 62;
         3:  rho = 28;
         4:  rho = 27;
         5:  rho = 36;
         6:  rho = 44;
         7:  rho = 6;
         8:  rho = 55;
         9:  rho = 20;
         10: rho = 3;
         11: rho = 10;
         12: rho = 43;
         13: rho = 25;
         14: rho = 39;
         15: rho = 41;
         16: rho = 45;
         17: rho = 15;
         18: rho = 21;
         19: rho = 8;
         20: rho = 18;
         21: rho = 2;
         22: rho = 61;
         23: rho = 56;
         24: rho = 14;
         default: rho = 0;
      endcase
      r = rho % N;
      steps_for = CW'((N - r) % N);
   endfunction

   always_comb begin
      k = steps_for(lane_idx);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         sreg      <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sreg     <= lane_in;
                  cnt      <= k;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (k != '0) begin
                     state <= ROT;
                  end else begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                  end
               end
            end
            ROT: begin
               sreg <= {sreg[0], sreg[N-1:1]};
               cnt  <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state     <= HOLD;
                  out_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign lane_out = sreg;

endmodule

// File: tb/tb_lane_rotator.sv
// Bench for lane_rotator: directed cases plus a randomized index sweep,
// checked against a rotate-left reference computed from the rho table.
module tb_lane_rotator;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] lane_in;
   logic [4:0]  lane_idx;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] lane_out;
   logic        busy;

   int checks = 0;
   int errors = 0;

   int unsigned RHO [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                             41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

   lane_rotator #(.N(64), .IDX_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .lane_in(lane_in), .lane_idx(lane_idx),
      .out_valid(out_valid), .out_ready(out_ready),
      .lane_out(lane_out), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int unsigned rot_amt(input int unsigned idx);
      return (idx < 25) ? RHO[idx] % 64 : 0;
   endfunction

   function automatic logic [63:0] ref_rot(input logic [63:0] x, input int unsigned idx);
      logic [63:0] y;
      int unsigned r;
      r = rot_amt(idx);
      y = '0;
      for (int i = 0; i < 64; i++) y[(i + r) % 64] = x[i];
      return y;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: accept, wait for result, hold, release.
   task automatic do_lane(input string tag, input logic [4:0] idx, input logic [63:0] lane,
                          input int unsigned hold, input bit noise);
      logic [63:0] exp;
      int unsigned k;
      int cycles;
      int busy_cnt;
      exp = ref_rot(lane, 32'(idx));
      k = (64 - rot_amt(32'(idx))) % 64;
      chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
      lane_in = lane;
      lane_idx = idx;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      cycles = 0;
      busy_cnt = 0;
      while (out_valid !== 1'b1 && cycles < 100) begin
         if (busy === 1'b1 && in_ready === 1'b0) busy_cnt++;
         if (noise) begin
            in_valid = 1'($urandom);
            lane_in = {$urandom, $urandom};
            lane_idx = 5'($urandom);
            out_ready = 1'($urandom);
         end
         step();
         cycles++;
      end
      out_ready = 1'b0;
      chk({tag, ".latency"}, 64'(cycles), 64'(k));
      chk({tag, ".busy_rot"}, 64'(busy_cnt), 64'(k));
      chk({tag, ".lane_out"}, lane_out, exp);
      chk({tag, ".busy_hold"}, 64'(busy), 64'd1);
      for (int h = 0; h < int'(hold); h++) begin
         step();
         chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
         chk({tag, ".hold_data"}, lane_out, exp);
         chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk({tag, ".done_valid"}, 64'(out_valid), 64'd0);
      chk({tag, ".done_busy"}, 64'(busy), 64'd0);
      chk({tag, ".done_in_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      lane_in = '0;
      lane_idx = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.out_valid", 64'(out_valid), 64'd0);
      chk("reset.busy", 64'(busy), 64'd0);
      chk("reset.lane_out", lane_out, 64'd0);
      rst = 1'b1;
      step();
      chk("reset.in_ready", 64'(in_ready), 64'd1);

      do_lane("T1", 5'd0, 64'h0123_4567_89AB_CDEF, 0, 1'b0);
      do_lane("T2", 5'd1, 64'h1, 0, 1'b0);
      do_lane("T3", 5'd2, 64'h1, 0, 1'b0);
      do_lane("T4", 5'd6, 64'hFFFF_0000_0000_0001, 10, 1'b0);
      chk("T4.ref", ref_rot(64'hFFFF_0000_0000_0001, 6), 64'h0000_1FFF_F000_0000);

      // T5: abort a rotation part-way with reset
      lane_in = 64'h1;
      lane_idx = 5'd1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (20) step();
      rst = 1'b0;
      #1;
      chk("T5.rst_valid", 64'(out_valid), 64'd0);
      chk("T5.rst_busy", 64'(busy), 64'd0);
      step();
      rst = 1'b1;
      step();
      chk("T5.in_ready", 64'(in_ready), 64'd1);
      chk("T5.busy", 64'(busy), 64'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("T5.no_emit", 64'(out_valid), 64'd0);
      end
      do_lane("T5b", 5'd0, 64'hDEAD_BEEF_CAFE_F00D, 1, 1'b0);

      for (int i = 0; i < 26; i++) begin
         logic [4:0] idx;
         idx = (i == 25) ? 5'd31 : 5'(i);
         do_lane($sformatf("T6.%0d", idx), idx, {$urandom, $urandom},
                 $urandom_range(0, 3), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
